meas_scheduler: RTL

// Sequences the shared ADC measurement path. Alternates a frequency measurement (gate window

---
 rtl/meas_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/meas_scheduler.sv
// Measurement scheduler for the shared ADC path.
// Runs one measurement cycle at a time: a frequency gate window, a wait for the
// frequency result, a duty-meter arm pulse, a wait for the duty result, and a
// hold gap. Each result is latched and announced with a one-cycle valid strobe.
// A phase that gets no result in time publishes 0 and raises a sticky error bit.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   enable                   level, auto-repeat measurement cycles
//   start                    pulse, request one cycle (taken only when idle)
//   err_clr                  pulse, clear sticky timeout flags
//   freq_gate                frequency meter counts while high
//   freq_done/freq_count_in  frequency result handshake and count
//   duty_start               pulse, arm the duty meter
//   duty_done/duty_in        duty result handshake and value (0.01 % units)
//   freq_data/freq_valid     latched frequency and its update strobe
//   duty_data/duty_valid     latched, clamped duty and its update strobe
//   busy                     high whenever a cycle is in progress
//   timeout_err              sticky [0] freq timeout, [1] duty timeout
module meas_scheduler #(
    parameter int unsigned GATE_CYCLES    = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES    = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic        err_clr,
    output logic        freq_gate,
    input  logic        freq_done,
    input  logic [31:0] freq_count_in,
    output logic        duty_start,
    input  logic        duty_done,
    input  logic [15:0] duty_in,
    output logic [31:0] freq_data,
    output logic        freq_valid,
    output logic [15:0] duty_data,
    output logic        duty_valid,
    output logic        busy,
    output logic [1:0]  timeout_err
);

    localparam int unsigned MAX_A   = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned FREQ_W  = 32;
    localparam int unsigned DUTY_W  = 16;
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(10000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_F_WAIT,
        S_D_REQ,
        S_D_WAIT,
        S_HOLD
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [FREQ_W-1:0]   freq_data_nx;
    logic [DUTY_W-1:0]   duty_data_nx;
    logic                freq_valid_nx, duty_valid_nx;
    logic [1:0]          err_set, err_nx;
    logic                freq_gate_nx, duty_start_nx, busy_nx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state, phase counter and result capture; the counter reloads on every phase entry
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        freq_data_nx  = freq_data;
        duty_data_nx  = duty_data;
        freq_valid_nx = 1'b0;
        duty_valid_nx = 1'b0;
        err_set       = 2'b00;

        case (state)
            S_IDLE: begin
                if (enable || start) begin
                    state_nx = S_GATE;
                    cnt_nx   = CNT_W'(GATE_CYCLES - 1);
                end
            end
            S_GATE: begin
                if (cnt == '0) begin
                    state_nx = S_F_WAIT;
                    cnt_nx   = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_F_WAIT: begin
                // A result arriving on the expiry cycle takes priority over the timeout
                if (freq_done) begin
                    freq_data_nx  = freq_count_in;
                    freq_valid_nx = 1'b1;
                    state_nx      = S_D_REQ;
                end else if (cnt == '0) begin
                    freq_data_nx  = '0;
                    freq_valid_nx = 1'b1;
                    err_set[0]    = 1'b1;
                    state_nx      = S_D_REQ;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_D_REQ: begin
                state_nx = S_D_WAIT;
                cnt_nx   = CNT_W'(TIMEOUT_CYCLES - 1);
            end
            S_D_WAIT: begin
                if (duty_done) begin
                    duty_data_nx  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
                    duty_valid_nx = 1'b1;
                    state_nx      = S_HOLD;
                    cnt_nx        = CNT_W'(HOLD_CYCLES - 1);
                end else if (cnt == '0) begin
                    duty_data_nx  = '0;
                    duty_valid_nx = 1'b1;
                    err_set[1]    = 1'b1;
                    state_nx      = S_HOLD;
                    cnt_nx        = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            default: state_nx = S_IDLE;
        endcase

        // A timeout raised in the same cycle as err_clr survives the clear
        err_nx        = (err_clr ? 2'b00 : timeout_err) | err_set;
        freq_gate_nx  = (state_nx == S_GATE);
        duty_start_nx = (state_nx == S_D_REQ);
        busy_nx       = (state_nx != S_IDLE);
    end

    // Output and datapath registers; reset drops the gate and arm pulse immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            freq_data   <= '0;
            duty_data   <= '0;
            freq_valid  <= 1'b0;
            duty_valid  <= 1'b0;
            timeout_err <= 2'b00;
            freq_gate   <= 1'b0;
            duty_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            freq_data   <= freq_data_nx;
            duty_data   <= duty_data_nx;
            freq_valid  <= freq_valid_nx;
            duty_valid  <= duty_valid_nx;
            timeout_err <= err_nx;
            freq_gate   <= freq_gate_nx;
            duty_start  <= duty_start_nx;
            busy        <= busy_nx;
        end
    end

endmodule
